// File: rtl/tlul_dev_adapter_pkg.sv
// Shared types for the TL-UL device-side adapter: FSM states and the captured A-channel request.
package tlul_dev_adapter_pkg;

  typedef enum logic [1:0] {IDLE, DEV_REQ, DEV_WAIT, RSP} state_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [7:0]  source;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } req_hold_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL bus types, opcodes and the 7-bit integrity fold shared by hosts and devices.
// The integrity code XOR-folds the covered bits into 7 lanes: bit i lands in lane i%7.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam tl_d2h_t TL_D2H_DEFAULT = '0;

  function automatic logic [6:0] intg_fold(input logic [63:0] v);
    logic [69:0] tmp;
    logic [6:0]  r;
    tmp = {6'b0, v};
    r   = '0;
    for (int k = 0; k < 10; k++) begin
      r   = r ^ tmp[6:0];
      tmp = tmp >> 7;
    end
    return r;
  endfunction

  function automatic logic [6:0] cmd_intg_gen(input logic [2:0] opcode, input logic [3:0] mask,
                                              input logic [31:0] addr);
    return intg_fold({25'b0, opcode, mask, addr});
  endfunction

  function automatic logic [6:0] data_intg_gen(input logic [31:0] data);
    return intg_fold({32'b0, data});
  endfunction

  function automatic logic [6:0] rsp_intg_gen(input logic [2:0] opcode, input logic [1:0] size,
                                              input logic error);
    return intg_fold({58'b0, opcode, size, error});
  endfunction

endpackage

// File: rtl/tlul_dev_req_check.sv
// Combinational TL-UL request legality check: opcode, size, alignment, mask lanes, read-only.
module tlul_dev_req_check
  import tlul_pkg::*;
#(
  parameter logic READ_ONLY = 1'b0
) (
  input  logic [2:0] i_opcode,
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lsb,
  input  logic [3:0] i_mask,
  output logic       err_o
);
  logic       w_put;
  logic       w_bad_op;
  logic       w_misalign;
  logic       w_mask_bad;
  logic [3:0] w_lane;

  always_comb begin
    w_put    = (i_opcode == PutFullData) || (i_opcode == PutPartialData);
    w_bad_op = !w_put && (i_opcode != Get);
    case (i_size)
      2'd0:    w_lane = 4'b0001 << i_addr_lsb;
      2'd1:    w_lane = i_addr_lsb[1] ? 4'b1100 : 4'b0011;
      default: w_lane = 4'hF;
    endcase
    w_misalign = ((i_size == 2'd1) && i_addr_lsb[0]) || ((i_size == 2'd2) && (i_addr_lsb != 2'd0));
    // Full writes must cover the whole word; any write must stay inside its size/address lane.
    w_mask_bad = ((i_opcode == PutFullData) && (i_mask != 4'hF)) || (w_put && |(i_mask & ~w_lane));
    err_o      = w_bad_op || (i_size == 2'd3) || w_misalign || w_mask_bad || (w_put && READ_ONLY);
  end

endmodule

// File: rtl/tlul_dev_to_simple.sv
// TL-UL device adapter: replays single-outstanding TL-UL requests onto a req/gnt/rvalid device port.
// Optional TLUL_DEV_INTG_CHECK_EN verifies A-channel integrity and flags failures on intg_err_o.
module tlul_dev_to_simple
  import tlul_pkg::*;
  import tlul_dev_adapter_pkg::*;
#(
  parameter logic        READ_ONLY = 1'b0,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  tl_h2d_t     tl_i,
  output tl_d2h_t     tl_o,
  output logic        req_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        intg_err_o
);
  state_e      r_state;
  state_e      w_state_nxt;
  req_hold_t   r_req;
  logic        r_lerr;
  logic        r_dev_err;
  logic [31:0] r_rdata;
  logic        w_chk_err;
  logic        w_intg_bad;
  logic        w_illegal;
  logic        w_accept;
  logic        w_held_put;
  logic        w_held_get;
  logic [2:0]  w_d_opcode;
  logic [31:0] w_d_data;
  logic        w_d_error;

  tlul_dev_req_check #(.READ_ONLY(READ_ONLY)) u_req_check (
    .i_opcode   (tl_i.a_opcode),
    .i_size     (tl_i.a_size),
    .i_addr_lsb (tl_i.a_address[1:0]),
    .i_mask     (tl_i.a_mask),
    .err_o      (w_chk_err)
  );

`ifdef TLUL_DEV_INTG_CHECK_EN
  logic r_intg_err;
  logic w_a_put;
  logic w_unused;

  assign w_a_put    = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign w_intg_bad = (tl_i.a_user.cmd_intg != cmd_intg_gen(tl_i.a_opcode, tl_i.a_mask, tl_i.a_address)) ||
                      (w_a_put && (tl_i.a_user.data_intg != data_intg_gen(tl_i.a_data)));
  assign intg_err_o = r_intg_err;
  assign w_unused   = ^tl_i.a_param;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                       r_intg_err <= 1'b0;
    else if (w_accept && w_intg_bad) r_intg_err <= 1'b1;
  end
`else
  logic w_unused;

  assign w_intg_bad = 1'b0;
  assign intg_err_o = 1'b0;
  assign w_unused   = ^{tl_i.a_param, tl_i.a_user};
`endif

  assign w_accept   = (r_state == IDLE) && tl_i.a_valid;
  assign w_illegal  = w_chk_err || w_intg_bad;
  assign w_held_put = (r_req.opcode == PutFullData) || (r_req.opcode == PutPartialData);
  assign w_held_get = (r_req.opcode == Get);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_o       = 1'b0;
    we_o        = 1'b0;
    be_o        = '0;
    addr_o      = '0;
    wdata_o     = '0;
    case (r_state)
      IDLE: begin
        if (tl_i.a_valid) w_state_nxt = w_illegal ? RSP : DEV_REQ;
      end
      DEV_REQ: begin
        req_o   = 1'b1;
        we_o    = w_held_put;
        be_o    = w_held_put ? r_req.mask : 4'hF;
        addr_o  = {r_req.addr[31:2], 2'b00};
        wdata_o = w_held_put ? r_req.data : 32'h0;
        if (gnt_i) w_state_nxt = DEV_WAIT;
      end
      DEV_WAIT: begin
        if (rvalid_i) w_state_nxt = RSP;
      end
      RSP: begin
        if (tl_i.d_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req     <= '0;
      r_lerr    <= 1'b0;
      r_dev_err <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_req.opcode <= tl_i.a_opcode;
        r_req.source <= tl_i.a_source;
        r_req.size   <= tl_i.a_size;
        r_req.addr   <= tl_i.a_address;
        r_req.mask   <= tl_i.a_mask;
        r_req.data   <= tl_i.a_data;
        r_lerr       <= w_illegal;
        r_dev_err    <= 1'b0;
        r_rdata      <= '0;
      end
      if ((r_state == DEV_WAIT) && rvalid_i) begin
        r_rdata   <= rdata_i;
        r_dev_err <= err_i;
      end
    end
  end

  assign w_d_opcode = w_held_get ? AccessAckData : AccessAck;
  assign w_d_error  = r_lerr || r_dev_err;
  assign w_d_data   = !w_held_get ? 32'h0 : (r_lerr ? ERR_RDATA : r_rdata);

  // a_ready is held low while reset is asserted, even though the state already reads IDLE.
  always_comb begin
    tl_o         = TL_D2H_DEFAULT;
    tl_o.a_ready = (r_state == IDLE) && !rst_i;
    if (r_state == RSP) begin
      tl_o.d_valid            = 1'b1;
      tl_o.d_opcode           = w_d_opcode;
      tl_o.d_size             = r_req.size;
      tl_o.d_source           = r_req.source;
      tl_o.d_data             = w_d_data;
      tl_o.d_error            = w_d_error;
      tl_o.d_user.rsp_intg    = rsp_intg_gen(w_d_opcode, r_req.size, w_d_error);
      tl_o.d_user.data_intg   = data_intg_gen(w_d_data);
    end
  end

`ifndef SYNTHESIS
  // A response still in flight across a reset is legal; only flag rvalid once a new request has gone out.
  logic r_fresh;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  r_fresh <= 1'b1;
    else if (r_state != IDLE)   r_fresh <= 1'b0;
  end

  a_rvalid_only_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
    (rvalid_i && !r_fresh) |-> (r_state == DEV_WAIT));
`endif

endmodule

// File: tb/tb_tlul_dev_to_simple.sv
// Directed bench for tlul_dev_to_simple: a read-write instance and a READ_ONLY instance share stimulus via sel.
module tb_tlul_dev_to_simple;
  import tlul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        corrupt;
  tl_h2d_t     h2d, h2d_rw, h2d_ro;
  tl_d2h_t     d2h, d2h_rw, d2h_ro;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic        req_rw, we_rw, req_ro, we_ro, ie_rw, ie_ro;
  logic [3:0]  be_rw, be_ro;
  logic [31:0] addr_rw, addr_ro, wd_rw, wd_ro;
  logic        req, we, intg;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  int vec  = 0;
  int errs = 0;

  always_comb begin
    h2d_rw         = h2d;
    h2d_ro         = h2d;
    h2d_rw.a_valid = h2d.a_valid & ~sel;
    h2d_rw.d_ready = h2d.d_ready & ~sel;
    h2d_ro.a_valid = h2d.a_valid & sel;
    h2d_ro.d_ready = h2d.d_ready & sel;
  end

  assign d2h   = sel ? d2h_ro  : d2h_rw;
  assign req   = sel ? req_ro  : req_rw;
  assign we    = sel ? we_ro   : we_rw;
  assign be    = sel ? be_ro   : be_rw;
  assign addr  = sel ? addr_ro : addr_rw;
  assign wdata = sel ? wd_ro   : wd_rw;
  assign intg  = sel ? ie_ro   : ie_rw;

  tlul_dev_to_simple #(.READ_ONLY(1'b0)) u_dut (
    .clk_i (clk), .rst_i (rst), .tl_i (h2d_rw), .tl_o (d2h_rw),
    .req_o (req_rw), .we_o (we_rw), .be_o (be_rw), .addr_o (addr_rw), .wdata_o (wd_rw),
    .gnt_i (gnt & ~sel), .rvalid_i (rvalid & ~sel), .rdata_i (rdata), .err_i (err),
    .intg_err_o (ie_rw)
  );

  tlul_dev_to_simple #(.READ_ONLY(1'b1)) u_ro (
    .clk_i (clk), .rst_i (rst), .tl_i (h2d_ro), .tl_o (d2h_ro),
    .req_o (req_ro), .we_o (we_ro), .be_o (be_ro), .addr_o (addr_ro), .wdata_o (wd_ro),
    .gnt_i (gnt & sel), .rvalid_i (rvalid & sel), .rdata_i (rdata), .err_i (err),
    .intg_err_o (ie_ro)
  );

  function automatic logic [6:0] exp_data_intg(input logic [31:0] d);
    return d[6:0] ^ d[13:7] ^ d[20:14] ^ d[27:21] ^ {3'b0, d[31:28]};
  endfunction

  function automatic logic [6:0] exp_cmd_intg(input logic [2:0] op, input logic [3:0] mk, input logic [31:0] ad);
    logic [38:0] v;
    v = {op, mk, ad};
    return v[6:0] ^ v[13:7] ^ v[20:14] ^ v[27:21] ^ v[34:28] ^ {3'b0, v[38:35]};
  endfunction

  function automatic tl_d2h_t mk_rsp(input logic [2:0] op, input logic [7:0] src, input logic [1:0] sz,
                                     input logic [31:0] dat, input logic er);
    tl_d2h_t r;
    r                  = '0;
    r.d_valid          = 1'b1;
    r.d_opcode         = op;
    r.d_size           = sz;
    r.d_source         = src;
    r.d_data           = dat;
    r.d_error          = er;
    r.d_user.rsp_intg  = {1'b0, op, sz, er};
    r.d_user.data_intg = exp_data_intg(dat);
    return r;
  endfunction

  task automatic drive_a(input logic [2:0] op, input logic [7:0] src, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [3:0] mk, input logic [31:0] dt);
    h2d                    = '0;
    h2d.a_opcode           = op;
    h2d.a_source           = src;
    h2d.a_size             = sz;
    h2d.a_address          = ad;
    h2d.a_mask             = mk;
    h2d.a_data             = dt;
    h2d.a_user.cmd_intg    = exp_cmd_intg(op, mk, ad) ^ {6'b0, corrupt};
    h2d.a_user.data_intg   = exp_data_intg(dt);
    h2d.a_valid            = 1'b1;
  endtask

  // Observations of the last transaction, filled by do_txn.
  bit          o_req_seen, o_stable;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata;
  int          o_lat;
  tl_d2h_t     o_rsp;

  // One A-request plus a device model: gnt after gw req cycles, rvalid rw cycles after gnt, d_ready after dw cycles.
  task automatic do_txn(input logic [2:0] op, input logic [7:0] src, input logic [1:0] sz, input logic [31:0] ad,
                        input logic [3:0] mk, input logic [31:0] dt, input int gw, input int rw,
                        input logic [31:0] rd, input logic de, input int dw);
    int gcnt, rcnt;
    drive_a(op, src, sz, ad, mk, dt);
    @(posedge clk); #1;
    h2d.a_valid = 1'b0;
    o_req_seen = 0; o_stable = 1; o_lat = 1; gcnt = 0; rcnt = -1;
    while (!d2h.d_valid && o_lat < 100) begin
      gnt = 1'b0; rvalid = 1'b0;
      if (d2h.a_ready) o_stable = 0;
      if (req) begin
        if (!o_req_seen) begin
          o_we = we; o_be = be; o_addr = addr; o_wdata = wdata;
        end else if ({we, be, addr, wdata} !== {o_we, o_be, o_addr, o_wdata}) o_stable = 0;
        o_req_seen = 1;
        if (gcnt >= gw) begin gnt = 1'b1; rcnt = 0; end
        gcnt++;
      end else if (rcnt >= 0) begin
        if (rcnt >= rw) begin rvalid = 1'b1; rdata = rd; err = de; rcnt = -1; end
        else rcnt++;
      end
      @(posedge clk); #1;
      o_lat++;
    end
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
    o_rsp = d2h;
    repeat (dw) begin
      @(posedge clk); #1;
      if (d2h !== o_rsp) o_stable = 0;
    end
    h2d.d_ready = 1'b1;
    @(posedge clk); #1;
    h2d.d_ready = 1'b0;
  endtask

  task automatic test_reset;
    tl_d2h_t e;
    rst = 1'b1; sel = 1'b0; corrupt = 1'b0; h2d = '0;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
    repeat (2) @(posedge clk); #1;
    vec++;
    if ({req, we, be, addr, wdata, intg, d2h.d_valid, d2h.a_ready} !== '0) begin
      errs++;
      $display("FAIL reset_hold req=%b we=%b be=%h addr=%h wd=%h ie=%b dv=%b ar=%b want all 0",
               req, we, be, addr, wdata, intg, d2h.d_valid, d2h.a_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    e = '0; e.a_ready = 1'b1;
    vec++;
    if (d2h !== e) begin errs++; $display("FAIL reset_idle d2h=%h want %h", d2h, e); end
  endtask

  task automatic test_get;
    do_txn(Get, 8'h5A, 2'd2, 32'h100, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 0);
    vec++;
    if (!o_req_seen || {o_we, o_be, o_addr} !== {1'b0, 4'hF, 32'h100}) begin
      errs++; $display("FAIL get_req seen=%0b we=%b be=%h addr=%h want 1 0 f 00000100", o_req_seen, o_we, o_be, o_addr);
    end
    vec++;
    if (o_lat != 3) begin errs++; $display("FAIL get_latency got=%0d want 3", o_lat); end
    vec++;
    if (o_rsp !== mk_rsp(AccessAckData, 8'h5A, 2'd2, 32'hDEADBEEF, 1'b0)) begin
      errs++; $display("FAIL get_rsp got=%h want %h", o_rsp, mk_rsp(AccessAckData, 8'h5A, 2'd2, 32'hDEADBEEF, 1'b0));
    end
    vec++;
    if (d2h.d_valid !== 1'b0 || d2h.a_ready !== 1'b1) begin
      errs++; $display("FAIL get_done dv=%b ar=%b want 0 1", d2h.d_valid, d2h.a_ready);
    end
  endtask

  task automatic test_put_partial;
    do_txn(PutPartialData, 8'h11, 2'd1, 32'h204, 4'b0011, 32'h1234, 0, 0, 32'h0, 1'b0, 0);
    vec++;
    if (!o_req_seen || {o_we, o_be, o_addr, o_wdata} !== {1'b1, 4'b0011, 32'h204, 32'h1234}) begin
      errs++; $display("FAIL put_req seen=%0b we=%b be=%h addr=%h wd=%h want 1 1 3 00000204 00001234",
                       o_req_seen, o_we, o_be, o_addr, o_wdata);
    end
    vec++;
    if (o_lat != 3 || o_rsp !== mk_rsp(AccessAck, 8'h11, 2'd1, 32'h0, 1'b0)) begin
      errs++; $display("FAIL put_rsp lat=%0d got=%h want lat 3 %h", o_lat, o_rsp, mk_rsp(AccessAck, 8'h11, 2'd1, 32'h0, 1'b0));
    end
  endtask

  task automatic test_sub_word;
    // Byte Get at a non-zero offset is legal: word address, full byte enables.
    do_txn(Get, 8'h31, 2'd0, 32'h103, 4'h1, 32'h0, 0, 0, 32'h8899AABB, 1'b0, 0);
    vec++;
    if (!o_req_seen || {o_we, o_be, o_addr} !== {1'b0, 4'hF, 32'h100} ||
        o_rsp !== mk_rsp(AccessAckData, 8'h31, 2'd0, 32'h8899AABB, 1'b0)) begin
      errs++; $display("FAIL byte_get seen=%0b be=%h addr=%h rsp=%h", o_req_seen, o_be, o_addr, o_rsp);
    end
    do_txn(PutPartialData, 8'h32, 2'd0, 32'h42, 4'b0100, 32'h00AA0000, 0, 0, 32'h0, 1'b0, 0);
    vec++;
    if (!o_req_seen || {o_we, o_be, o_addr} !== {1'b1, 4'b0100, 32'h40} ||
        o_rsp !== mk_rsp(AccessAck, 8'h32, 2'd0, 32'h0, 1'b0)) begin
      errs++; $display("FAIL byte_put seen=%0b be=%h addr=%h rsp=%h", o_req_seen, o_be, o_addr, o_rsp);
    end
  endtask

  task automatic test_local_err;
    logic [2:0]  t_op [6];
    logic [1:0]  t_sz [6];
    logic [31:0] t_ad [6];
    logic [3:0]  t_mk [6];
    tl_d2h_t     e;
    t_op = '{PutFullData, Get, Get, 3'h2, PutPartialData, PutPartialData};
    t_sz = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
    t_ad = '{32'h40, 32'h102, 32'h0, 32'h0, 32'h41, 32'h41};
    t_mk = '{4'h7, 4'hF, 4'hF, 4'hF, 4'b0001, 4'b0110};
    for (int i = 0; i < 6; i++) begin
      do_txn(t_op[i], 8'h20 + 8'(i), t_sz[i], t_ad[i], t_mk[i], 32'h5555AAAA, 0, 0, 32'h0, 1'b0, 0);
      e = mk_rsp((t_op[i] == Get) ? AccessAckData : AccessAck, 8'h20 + 8'(i), t_sz[i],
                 (t_op[i] == Get) ? 32'hFFFF_FFFF : 32'h0, 1'b1);
      vec++;
      if (o_req_seen || o_lat != 1 || o_rsp !== e) begin
        errs++; $display("FAIL local_err[%0d] req_seen=%0b lat=%0d rsp=%h want 0 1 %h", i, o_req_seen, o_lat, o_rsp, e);
      end
    end
  endtask

  task automatic test_dev_err;
    do_txn(Get, 8'h44, 2'd2, 32'h80, 4'hF, 32'h0, 0, 0, 32'h0BAD0BAD, 1'b1, 0);
    vec++;
    if (o_lat != 3 || o_rsp.d_error !== 1'b1 || o_rsp.d_opcode !== AccessAckData) begin
      errs++; $display("FAIL dev_err lat=%0d err=%b op=%h want 3 1 1", o_lat, o_rsp.d_error, o_rsp.d_opcode);
    end
  endtask

  task automatic test_read_only;
    sel = 1'b1;
    do_txn(PutFullData, 8'h66, 2'd2, 32'h8, 4'hF, 32'h01020304, 0, 0, 32'h0, 1'b0, 0);
    vec++;
    if (o_req_seen || o_lat != 1 || o_rsp !== mk_rsp(AccessAck, 8'h66, 2'd2, 32'h0, 1'b1)) begin
      errs++; $display("FAIL ro_put req_seen=%0b lat=%0d rsp=%h", o_req_seen, o_lat, o_rsp);
    end
    do_txn(Get, 8'h67, 2'd2, 32'hC, 4'hF, 32'h0, 0, 0, 32'hCAFEF00D, 1'b0, 0);
    vec++;
    if (!o_req_seen || o_lat != 3 || o_rsp !== mk_rsp(AccessAckData, 8'h67, 2'd2, 32'hCAFEF00D, 1'b0)) begin
      errs++; $display("FAIL ro_get req_seen=%0b lat=%0d rsp=%h", o_req_seen, o_lat, o_rsp);
    end
    sel = 1'b0;
  endtask

  task automatic test_stall;
    do_txn(PutFullData, 8'h77, 2'd2, 32'h300, 4'hF, 32'hA5A55A5A, 5, 1, 32'h0, 1'b0, 4);
    vec++;
    if (!o_stable || o_lat != 9) begin
      errs++; $display("FAIL stall stable=%0b lat=%0d want 1 9", o_stable, o_lat);
    end
    vec++;
    if ({o_we, o_be, o_addr, o_wdata} !== {1'b1, 4'hF, 32'h300, 32'hA5A55A5A} ||
        o_rsp !== mk_rsp(AccessAck, 8'h77, 2'd2, 32'h0, 1'b0)) begin
      errs++; $display("FAIL stall_fields be=%h addr=%h wd=%h rsp=%h", o_be, o_addr, o_wdata, o_rsp);
    end
  endtask

  task automatic test_back_to_back;
    do_txn(Get, 8'h01, 2'd2, 32'h10, 4'hF, 32'h0, 0, 2, 32'h11111111, 1'b0, 0);
    vec++;
    if (o_lat != 5 || o_rsp !== mk_rsp(AccessAckData, 8'h01, 2'd2, 32'h11111111, 1'b0)) begin
      errs++; $display("FAIL b2b_first lat=%0d rsp=%h", o_lat, o_rsp);
    end
    do_txn(Get, 8'h02, 2'd2, 32'h14, 4'hF, 32'h0, 0, 0, 32'h22222222, 1'b0, 0);
    vec++;
    if (o_lat != 3 || o_rsp !== mk_rsp(AccessAckData, 8'h02, 2'd2, 32'h22222222, 1'b0)) begin
      errs++; $display("FAIL b2b_second lat=%0d rsp=%h", o_lat, o_rsp);
    end
  endtask

  task automatic test_rst_mid;
    // Reset in DEV_REQ drops req_o without waiting for a clock.
    drive_a(Get, 8'h90, 2'd2, 32'h500, 4'hF, 32'h0);
    @(posedge clk); #1;
    h2d.a_valid = 1'b0;
    rst = 1'b1; #1;
    vec++;
    if (req !== 1'b0) begin errs++; $display("FAIL rst_dev_req req=%b want 0", req); end
    @(posedge clk); #1; rst = 1'b0;
    // Reset in DEV_WAIT, then a late rvalid must not produce a response.
    drive_a(Get, 8'h91, 2'd2, 32'h504, 4'hF, 32'h0);
    @(posedge clk); #1;
    h2d.a_valid = 1'b0; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0; rst = 1'b1; #1;
    vec++;
    if (req !== 1'b0 || d2h.d_valid !== 1'b0) begin
      errs++; $display("FAIL rst_dev_wait req=%b dv=%b want 0 0", req, d2h.d_valid);
    end
    @(posedge clk); #1; rst = 1'b0; #1;
    vec++;
    if (d2h.a_ready !== 1'b1) begin errs++; $display("FAIL rst_release ar=%b want 1", d2h.a_ready); end
    rvalid = 1'b1; rdata = 32'h12345678;
    @(posedge clk); #1; rvalid = 1'b0;
    repeat (3) begin
      vec++;
      if (d2h.d_valid !== 1'b0 || req !== 1'b0) begin
        errs++; $display("FAIL late_rvalid dv=%b req=%b want 0 0", d2h.d_valid, req);
      end
      @(posedge clk); #1;
    end
    // Reset while a local error response waits for d_ready.
    drive_a(PutFullData, 8'h92, 2'd2, 32'h508, 4'h7, 32'h0);
    @(posedge clk); #1;
    h2d.a_valid = 1'b0;
    vec++;
    if (d2h.d_valid !== 1'b1) begin errs++; $display("FAIL rsp_before_rst dv=%b want 1", d2h.d_valid); end
    rst = 1'b1; #1;
    vec++;
    if (d2h.d_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp dv=%b want 0", d2h.d_valid); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_intg;
`ifdef TLUL_DEV_INTG_CHECK_EN
    corrupt = 1'b1;
    do_txn(Get, 8'hA0, 2'd2, 32'h600, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 0);
    corrupt = 1'b0;
    vec++;
    if (o_req_seen || o_lat != 1 || o_rsp !== mk_rsp(AccessAckData, 8'hA0, 2'd2, 32'hFFFF_FFFF, 1'b1)) begin
      errs++; $display("FAIL intg_bad req_seen=%0b lat=%0d rsp=%h", o_req_seen, o_lat, o_rsp);
    end
    do_txn(Get, 8'hA1, 2'd2, 32'h604, 4'hF, 32'h0, 0, 0, 32'h76543210, 1'b0, 0);
    vec++;
    if (intg !== 1'b1 || o_rsp !== mk_rsp(AccessAckData, 8'hA1, 2'd2, 32'h76543210, 1'b0)) begin
      errs++; $display("FAIL intg_sticky ie=%b rsp=%h want 1", intg, o_rsp);
    end
`else
    vec++;
    if (intg !== 1'b0) begin errs++; $display("FAIL intg_tied ie=%b want 0", intg); end
`endif
  endtask

  initial begin
    test_reset();
    test_get();
    test_put_partial();
    test_sub_word();
    test_local_err();
    test_dev_err();
    test_read_only();
    test_stall();
    test_back_to_back();
    test_rst_mid();
    test_intg();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vec);
    $fatal(1);
  end

endmodule

// File: doc/tlul_dev_to_simple.md
Name: tlul_dev_to_simple

Overview:
TL-UL device-port adapter that accepts TL-UL requests from the crossbar and replays them on a simple req/gnt/rvalid memory-side interface (Ibex-style), e.g. boot ROM, SRAM or CSR bank.
- Strictly single-outstanding.
- Checks request legality locally and returns a local error response for illegal requests.
- Builds a fully formed D-channel response, including integrity bits.
- Mirror of the Ibex-to-TL-UL host adapter on the device side of the secure_boot fabric.

Parameters:
READ_ONLY, 1'b0, when 1 every Put* is rejected with d_error=1 and is not forwarded
ERR_RDATA, 32'hFFFF_FFFF, d_data returned on locally errored Get responses

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous, active-high reset
tl_i  input  tlul_pkg::tl_h2d_t  TL-UL A-channel in, plus d_ready
tl_o  output  tlul_pkg::tl_d2h_t  TL-UL D-channel out, plus a_ready
req_o  output  1  device request
we_o  output  1  write enable
be_o  output  4  byte enables
addr_o  output  32  word address (a_address with [1:0] forced to 0)
wdata_o  output  32  write data
gnt_i  input  1  device grant
rvalid_i  input  1  device response valid (earliest one cycle after gnt)
rdata_i  input  32  device read data
err_i  input  1  device error, qualified by rvalid_i
intg_err_o  output  1  sticky integrity-failure flag (only with optional feature)

Behaviour:
- Reset values: all FSM and holding registers cleared; state=IDLE; a_ready=0, then 1 in IDLE; d_valid=0; req_o=0; intg_err_o=0. Other outputs are 0 / TL_D2H_DEFAULT.
- FSM states: IDLE, DEV_REQ, DEV_WAIT, RSP.
- IDLE:
  - a_ready=1.
  - On a_valid, capture opcode/source/size/address/mask/data into holding registers.
  - Legal request -> DEV_REQ. Illegal request -> RSP with err=1, no device access.
- Illegal request is any of:
  - opcode not in {Get, PutFullData, PutPartialData};
  - a_size>2;
  - address misaligned to a_size;
  - PutFullData with mask!=4'hF;
  - Put* mask bits outside the a_size/address lane;
  - Put* when READ_ONLY=1.
- DEV_REQ:
  - req_o=1 with held fields; we_o=1 for Put*; be_o=mask for Put*, 4'hF for Get.
  - gnt_i -> DEV_WAIT. req_o drops in the cycle after gnt.
- DEV_WAIT:
  - rvalid_i -> capture rdata_i/err_i, go to RSP.
  - rvalid_i in DEV_REQ/IDLE is ignored (protocol violation; assertion).
- RSP:
  - d_valid=1, held stable until d_ready. On d_ready, go to IDLE; the next a_valid is accepted no earlier than the following cycle.
- Response fields:
  - d_opcode: AccessAckData for Get, AccessAck for Put*.
  - d_source, d_size: echoed from the request.
  - d_error: local error OR err_i.
  - d_data: rdata for a good Get; ERR_RDATA for a locally errored Get; 0 for Put*.
  - d_user.rsp_intg / d_user.data_intg: generated with tlul_pkg functions from the final D fields.
- Latency: a-handshake to d_valid = 1 + gnt wait + rvalid wait; minimum 3 cycles forwarded, 1 cycle local error.
- Throughput: a_ready=0 outside IDLE; no back-to-back overlap.
- Reset mid-operation: immediate return to IDLE, req_o and d_valid deassert asynchronously; an in-flight device response after reset is dropped.

Optional Feature:
TLUL_DEV_INTG_CHECK_EN:
- Defined:
  - In IDLE, recompute cmd_intg over the A-channel and data_intg over a_data (Put* only).
  - On mismatch, treat the request as illegal (local error response, no device access) and set intg_err_o=1 sticky until reset.
- Undefined: no check; intg_err_o tied 0.

Decomposition:
- Shared package tlul_dev_adapter_pkg:
  - state enum (IDLE/DEV_REQ/DEV_WAIT/RSP);
  - a request-holding struct (opcode, source, size, addr, mask, data);
  - ERR_RDATA default.
- Integrity/encoding reuses tlul_pkg.
- One natural sub-module, tlul_dev_req_check: combinational legality check producing err_o from the A-channel fields and READ_ONLY.

Test Plan:
- Get addr 0x100, device gnt at once, rvalid 1 cycle later with rdata 0xDEADBEEF -> d_valid on cycle 3: AccessAckData, d_data=0xDEADBEEF, d_error=0, source echoed, rsp_intg correct.
- PutPartialData addr 0x204, mask 4'b0011, data 0x1234 -> req_o with we_o=1, be_o=4'b0011, addr_o=0x204; then AccessAck, d_error=0.
- PutFullData mask 4'h7 -> no req_o; d_valid next cycle with d_error=1. Same for a Get of size 2 at addr 0x102.
- READ_ONLY=1, PutFullData -> d_error=1, req_o never asserted. Get still returns device data.
- Device stalls gnt 5 cycles and d_ready held low 4 cycles -> req_o stable, a_ready=0 throughout, d fields stable until d_ready.
- Assert rst_i during DEV_WAIT -> req_o=0, d_valid=0, a_ready=1 after release; a late rvalid_i produces no response. With TLUL_DEV_INTG_CHECK_EN, corrupt cmd_intg bit 0 -> d_error=1 and intg_err_o=1.
